// File: rtl/tl_mc_fifo_if.sv
// Bus bundle for tl_mc_fifo: valid/ready write side, channel-addressed read side,
// per-channel flush and the registered status flags.
interface tl_mc_fifo_if #(
  parameter int NUM_CH       = 4,
  parameter int CH_DEPTH_LG2 = 4,
  parameter int DATA_WIDTH   = 256
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = CH_DEPTH_LG2 + 1;

  logic                      wvalid_i;
  logic [CH_W-1:0]           wch_i;
  logic [DATA_WIDTH-1:0]     wdata_i;
  logic                      wready_o;
  logic                      rreq_i;
  logic [CH_W-1:0]           rch_i;
  logic                      rvalid_o;
  logic [CH_W-1:0]           rch_o;
  logic [DATA_WIDTH-1:0]     rdata_o;
  logic [NUM_CH-1:0]         flush_i;
  logic [NUM_CH-1:0]         full_o;
  logic [NUM_CH-1:0]         afull_o;
  logic [NUM_CH-1:0]         empty_o;
  logic [NUM_CH*CNT_W-1:0]   cnt_o;
  logic [31:0]               debug_o;

  modport master (
    output wvalid_i, wch_i, wdata_i, rreq_i, rch_i, flush_i,
    input  wready_o, rvalid_o, rch_o, rdata_o, full_o, afull_o, empty_o, cnt_o, debug_o
  );

  modport slave (
    input  wvalid_i, wch_i, wdata_i, rreq_i, rch_i, flush_i,
    output wready_o, rvalid_o, rch_o, rdata_o, full_o, afull_o, empty_o, cnt_o, debug_o
  );
endinterface

// File: rtl/tl_mc_fifo.sv
// Multi-channel transaction-layer FIFO: NUM_CH independent queues partitioned
// inside one simple-dual-port RAM, with per-channel flags, flush and underflow capture.
module tl_mc_fifo #(
  parameter int NUM_CH       = 4,
  parameter int CH_DEPTH_LG2 = 4,
  parameter int DATA_WIDTH   = 256,
  parameter int AFULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  tl_mc_fifo_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW    = CH_DEPTH_LG2 + 1;
  localparam int DEPTH = 1 << CH_DEPTH_LG2;
  localparam int AW    = CH_W + CH_DEPTH_LG2;

  localparam logic [PW-1:0]   DEPTH_P  = DEPTH[PW-1:0];
  localparam logic [PW-1:0]   MARGIN_P = AFULL_MARGIN[PW-1:0];
  localparam logic [CH_W:0]   NUM_CH_P = NUM_CH[CH_W:0];

  logic [DATA_WIDTH-1:0] mem [NUM_CH*DEPTH];

  logic [PW-1:0]     wrptr   [NUM_CH];
  logic [PW-1:0]     rdptr   [NUM_CH];
  logic [PW-1:0]     cnt     [NUM_CH];
  logic [PW-1:0]     wrptr_n [NUM_CH];
  logic [PW-1:0]     rdptr_n [NUM_CH];
  logic [PW-1:0]     cnt_n   [NUM_CH];
  logic [NUM_CH-1:0] full, afull, empty, undrflown;
  logic [NUM_CH-1:0] full_n, afull_n, empty_n;

  logic                  wch_ok, rch_ok;
  logic                  wr_acc, rd_acc, rd_unf;
  logic [NUM_CH-1:0]     wr_sel, rd_sel, unf_sel;
  logic [AW-1:0]         waddr, raddr;
  logic                  rvalid;
  logic [CH_W-1:0]       rch;
  logic [DATA_WIDTH-1:0] rdata;

  // Channel numbers beyond NUM_CH (non power-of-two counts) are never accepted.
  assign wch_ok = {1'b0, bus.wch_i} < NUM_CH_P;
  assign rch_ok = {1'b0, bus.rch_i} < NUM_CH_P;

  assign wr_acc = bus.wvalid_i & wch_ok & ~full[bus.wch_i] & ~bus.flush_i[bus.wch_i];
  assign rd_acc = bus.rreq_i & rch_ok & ~empty[bus.rch_i] & ~bus.flush_i[bus.rch_i];
  assign rd_unf = bus.rreq_i & rch_ok & empty[bus.rch_i] & ~bus.flush_i[bus.rch_i];

  assign wr_sel  = wr_acc ? (NUM_CH'(1) << bus.wch_i) : '0;
  assign rd_sel  = rd_acc ? (NUM_CH'(1) << bus.rch_i) : '0;
  assign unf_sel = rd_unf ? (NUM_CH'(1) << bus.rch_i) : '0;

  assign waddr = {bus.wch_i, wrptr[bus.wch_i][CH_DEPTH_LG2-1:0]};
  assign raddr = {bus.rch_i, rdptr[bus.rch_i][CH_DEPTH_LG2-1:0]};

  // Flags are derived from the next pointers so they register in step with them.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wrptr_n[c] = wrptr[c] + PW'(wr_sel[c]);
      rdptr_n[c] = rdptr[c] + PW'(rd_sel[c]);
      cnt_n[c]   = cnt[c] + PW'(wr_sel[c]) - PW'(rd_sel[c]);
      if (bus.flush_i[c]) begin
        wrptr_n[c] = '0;
        rdptr_n[c] = '0;
        cnt_n[c]   = '0;
      end
      full_n[c]  = (wrptr_n[c][PW-1] != rdptr_n[c][PW-1]) &&
                   (wrptr_n[c][PW-2:0] == rdptr_n[c][PW-2:0]);
      empty_n[c] = (wrptr_n[c] == rdptr_n[c]);
      afull_n[c] = (DEPTH_P - cnt_n[c]) <= MARGIN_P;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wrptr[c] <= '0;
        rdptr[c] <= '0;
        cnt[c]   <= '0;
      end
      full      <= '1;
      afull     <= '1;
      empty     <= '1;
      undrflown <= '0;
      rvalid    <= 1'b0;
      rch       <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        wrptr[c] <= wrptr_n[c];
        rdptr[c] <= rdptr_n[c];
        cnt[c]   <= cnt_n[c];
      end
      full      <= full_n;
      afull     <= afull_n;
      empty     <= empty_n;
      undrflown <= undrflown | unf_sel;
      rvalid    <= rd_acc;
      if (rd_acc) begin
        rch <= bus.rch_i;
      end
    end
  end

  // Storage has no reset; rdata keeps its last value whenever nothing is returned.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[waddr] <= bus.wdata_i;
    end
    if (rst_n && rd_acc) begin
      rdata <= mem[raddr];
    end
  end

  assign bus.wready_o = wch_ok & ~full[bus.wch_i];
  assign bus.rvalid_o = rvalid;
  assign bus.rch_o    = rch;
  assign bus.rdata_o  = rdata;
  assign bus.full_o   = full;
  assign bus.afull_o  = afull;
  assign bus.empty_o  = empty;

  always_comb begin
    bus.cnt_o   = '0;
    bus.debug_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.cnt_o[c*PW +: PW] = cnt[c];
    end
    bus.debug_o[16 +: NUM_CH] = full;
    bus.debug_o[0 +: NUM_CH]  = undrflown;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ((unf_sel & ~undrflown) == '0)
        else $warning("tl_mc_fifo: read underflow on channel %0d", bus.rch_i);
    end
  end
`endif
endmodule

// File: tb/tb_tl_mc_fifo.sv
// Randomised bench for tl_mc_fifo checked against per-channel queue models.
module tb_tl_mc_fifo;
  localparam int NUM_CH = 4;
  localparam int LG2    = 4;
  localparam int DW     = 256;
  localparam int MARGIN = 2;
  localparam int DEPTH  = 16;
  localparam int CH_W   = 2;
  localparam int PW     = LG2 + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tl_mc_fifo_if #(.NUM_CH(NUM_CH), .CH_DEPTH_LG2(LG2), .DATA_WIDTH(DW)) bus ();

  tl_mc_fifo #(
    .NUM_CH(NUM_CH), .CH_DEPTH_LG2(LG2), .DATA_WIDTH(DW), .AFULL_MARGIN(MARGIN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [DW-1:0]     q [NUM_CH][$];
  logic [NUM_CH-1:0] m_undr;
  bit                m_in_rst, m_started, m_rvalid, m_has_rdata;
  logic [CH_W-1:0]   m_rch;
  logic [DW-1:0]     m_rdata;
  int                total, bad;

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] randData();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Registered outputs compared with what the queue model implies after the edge.
  task automatic checkState();
    logic [NUM_CH-1:0]    e_full, e_afull, e_empty;
    logic [NUM_CH*PW-1:0] e_cnt;
    logic [31:0]          e_dbg;
    int sz;
    e_cnt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sz = q[c].size();
      if (m_in_rst) begin
        e_full[c] = 1'b1; e_afull[c] = 1'b1; e_empty[c] = 1'b1;
      end else begin
        e_full[c]  = (sz == DEPTH);
        e_empty[c] = (sz == 0);
        e_afull[c] = (DEPTH - sz) <= MARGIN;
        e_cnt[c*PW +: PW] = sz[PW-1:0];
      end
    end
    e_dbg = '0;
    e_dbg[16 +: NUM_CH] = e_full;
    e_dbg[0 +: NUM_CH]  = m_undr;
    checkOutput("rvalid", bus.rvalid_o, m_rvalid);
    checkOutput("rch", bus.rch_o, m_rch);
    if (m_has_rdata) checkOutput("rdata", bus.rdata_o, m_rdata);
    checkOutput("full", bus.full_o, e_full);
    checkOutput("afull", bus.afull_o, e_afull);
    checkOutput("empty", bus.empty_o, e_empty);
    checkOutput("cnt", bus.cnt_o, e_cnt);
    checkOutput("debug", bus.debug_o, e_dbg);
  endtask

  task automatic applyStimulus(input bit wv, input int wch, input logic [DW-1:0] wd,
                               input bit rr, input int rch, input logic [NUM_CH-1:0] fl);
    bit w_ok, r_ok, unf;
    bus.wvalid_i = wv;
    bus.wch_i    = wch[CH_W-1:0];
    bus.wdata_i  = wd;
    bus.rreq_i   = rr;
    bus.rch_i    = rch[CH_W-1:0];
    bus.flush_i  = fl;
    #1;
    if (m_started) checkOutput("wready", bus.wready_o, !m_in_rst && (q[wch].size() < DEPTH));
    @(posedge clk);
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) q[c].delete();
      m_undr   = '0;
      m_in_rst = 1'b1;
      m_rvalid = 1'b0;
      m_rch    = '0;
    end else begin
      w_ok = wv && !m_in_rst && (q[wch].size() < DEPTH) && !fl[wch];
      r_ok = rr && (q[rch].size() > 0) && !fl[rch];
      unf  = rr && (q[rch].size() == 0) && !fl[rch];
      if (r_ok) begin
        m_rdata     = q[rch].pop_front();
        m_has_rdata = 1'b1;
        m_rch       = rch[CH_W-1:0];
      end
      m_rvalid = r_ok;
      if (w_ok) q[wch].push_back(wd);
      if (unf) m_undr[rch] = 1'b1;
      for (int c = 0; c < NUM_CH; c++) if (fl[c]) q[c].delete();
      m_in_rst = 1'b0;
    end
    m_started = 1'b1;
    #1;
    checkState();
  endtask

  task automatic idle();
    applyStimulus(0, 0, '0, 0, 0, '0);
  endtask

  task automatic pushOne(input int ch, input logic [DW-1:0] d);
    applyStimulus(1, ch, d, 0, 0, '0);
  endtask

  task automatic popOne(input int ch);
    applyStimulus(0, 0, '0, 1, ch, '0);
  endtask

  task automatic drainAll();
    for (int c = 0; c < NUM_CH; c++)
      for (int n = q[c].size(); n > 0; n--) popOne(c);
  endtask

  initial begin
    total = 0; bad = 0; m_undr = '0; m_has_rdata = 0; m_started = 0; m_in_rst = 0;
    m_rvalid = 0; m_rch = '0; m_rdata = '0;
    rst_n = 1'b0;

    for (int i = 0; i < 3; i++) idle();
    checkOutput("rst_wready", bus.wready_o, 1'b0);
    checkOutput("rst_full", bus.full_o, 4'hF);
    checkOutput("rst_empty", bus.empty_o, 4'hF);
    rst_n = 1'b1;
    idle();
    checkOutput("rel_full", bus.full_o, 4'h0);
    checkOutput("rel_cnt", bus.cnt_o, '0);
    checkOutput("rel_debug", bus.debug_o, 32'h0);

    // Fill channel 2, attempt an overflow write, then read everything back in order.
    for (int i = 0; i < DEPTH; i++) pushOne(2, DW'(i));
    checkOutput("ch2_full", bus.full_o[2], 1'b1);
    checkOutput("ch2_afull", bus.afull_o[2], 1'b1);
    pushOne(2, DW'(99));
    checkOutput("ch2_cnt_after_ovf", bus.cnt_o[2*PW +: PW], 5'd16);
    for (int i = 0; i < DEPTH; i++) begin
      popOne(2);
      checkOutput("ch2_order", bus.rdata_o, DW'(i));
      checkOutput("ch2_rch", bus.rch_o, 2'd2);
    end

    // Full channel 0 must not block channel 1.
    for (int i = 0; i < DEPTH; i++) pushOne(0, randData());
    for (int i = 0; i < 4; i++) pushOne(1, randData());
    checkOutput("ch1_cnt", bus.cnt_o[1*PW +: PW], 5'd4);
    for (int i = 0; i < 8; i++) popOne(i % 2);
    drainAll();

    // Steady push+pop on channel 3 across several pointer wraps.
    for (int i = 0; i < 5; i++) pushOne(3, randData());
    for (int i = 0; i < 100; i++) applyStimulus(1, 3, randData(), 1, 3, '0);
    checkOutput("ch3_cnt", bus.cnt_o[3*PW +: PW], 5'd5);
    drainAll();

    // Underflow on channel 1 is sticky through traffic and flush.
    popOne(1);
    checkOutput("undr_rvalid", bus.rvalid_o, 1'b0);
    checkOutput("undr_ch1", bus.debug_o[1], 1'b1);
    pushOne(1, randData());
    popOne(1);
    applyStimulus(0, 0, '0, 0, 0, 4'b0010);
    checkOutput("undr_sticky", bus.debug_o[1], 1'b1);

    // Flush channel 0 at cnt 7 with a concurrent write and read on it.
    for (int i = 0; i < 3; i++) pushOne(2, randData());
    for (int i = 0; i < 7; i++) pushOne(0, randData());
    applyStimulus(1, 0, randData(), 1, 0, 4'b0001);
    checkOutput("flush_cnt0", bus.cnt_o[0 +: PW], 5'd0);
    checkOutput("flush_empty0", bus.empty_o[0], 1'b1);
    checkOutput("flush_rvalid", bus.rvalid_o, 1'b0);
    checkOutput("flush_cnt2", bus.cnt_o[2*PW +: PW], 5'd3);

    // Random mixed traffic.
    for (int i = 0; i < 600; i++) begin
      logic [NUM_CH-1:0] fl;
      fl = ($urandom_range(0, 39) == 0) ? NUM_CH'(1 << $urandom_range(0, NUM_CH-1)) : '0;
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, NUM_CH-1), randData(),
                    $urandom_range(0, 9) < 5, $urandom_range(0, NUM_CH-1), fl);
    end

    // Reset in the middle of traffic suppresses the read issued that cycle.
    drainAll();
    pushOne(1, randData());
    pushOne(1, randData());
    rst_n = 1'b0;
    popOne(1);
    checkOutput("midrst_rvalid", bus.rvalid_o, 1'b0);
    rst_n = 1'b1;
    idle();
    checkOutput("midrst_empty", bus.empty_o, 4'hF);
    checkOutput("midrst_debug", bus.debug_o, 32'h0);
    pushOne(1, DW'(32'hABCD));
    popOne(1);
    checkOutput("midrst_data", bus.rdata_o, DW'(32'hABCD));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tl_mc_fifo.md
# tl_mc_fifo

Multi-channel transaction-layer FIFO: NUM_CH independent queues share one simple-dual-port RAM, partitioned by channel. It succeeds the single-queue TL FIFO for paths that carry several virtual channels (posted / non-posted / completion / message) and must not let one blocked channel stall another. The write side uses a valid/ready handshake. The read side is channel-addressed with a fixed one-cycle data latency. Per-channel full, almost-full, empty, count, flush and sticky underflow detection are provided.

## Interface
- NUM_CH, 4: number of channels, 2..16.
- CH_DEPTH_LG2, 4: log2 entries per channel.
- DATA_WIDTH, 256: payload width.
- AFULL_MARGIN, 2: afull_o[c] asserts when free entries ≤ AFULL_MARGIN; must be < 2^CH_DEPTH_LG2.
- CH_W (derived, not overridable): max(1, clog2(NUM_CH)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- wvalid_i  in  1  write request.
- wch_i  in  CH_W  write channel.
- wdata_i  in  DATA_WIDTH  write payload.
- wready_o  out  1  = ~full[wch_i]; write accepted on wvalid_i & wready_o.
- rreq_i  in  1  read (pop) request.
- rch_i  in  CH_W  read channel.
- rvalid_o  out  1  read data valid, one cycle after an accepted request.
- rch_o  out  CH_W  channel of the returned data.
- rdata_o  out  DATA_WIDTH  read payload.
- flush_i  in  NUM_CH  per-channel synchronous flush.
- full_o  out  NUM_CH  per-channel full, registered.
- afull_o  out  NUM_CH  per-channel almost-full, registered.
- empty_o  out  NUM_CH  per-channel empty, registered.
- cnt_o  out  NUM_CH*(CH_DEPTH_LG2+1)  occupancy; channel c is in slice [c*(CH_DEPTH_LG2+1) +: CH_DEPTH_LG2+1]; range 0..2^CH_DEPTH_LG2.
- debug_o  out  32  [31:16] full mask, [15:0] sticky underflow mask; bits ≥ NUM_CH are 0.

## Operation
- Per-channel state: wrptr and rdptr, each CH_DEPTH_LG2+1 bits (wrap bit included); cnt; full; afull; empty; undrflown.
- RAM has NUM_CH·2^CH_DEPTH_LG2 entries. Address is {channel, ptr[CH_DEPTH_LG2-1:0]}. Write port and read port are independent.
- Write accept: wvalid_i & ~full[wch_i] & ~flush_i[wch_i]. Writes wdata_i to {wch_i, wrptr}, then wrptr += 1, wrapping modulo 2^(CH_DEPTH_LG2+1).
- Read accept: rreq_i & ~empty[rch_i] & ~flush_i[rch_i]. Reads {rch_i, rdptr}, then rdptr += 1.
- Read request to an empty channel (flush not set): dropped, rvalid_o = 0 next cycle, undrflown[rch_i] set (sticky until reset). A simulation assertion fires on any undrflown bit.
- Read or write to a channel whose flush_i bit is set that cycle: dropped, no error. The flush clears wrptr, rdptr and cnt; empty = 1 and full = 0 next cycle. undrflown is not cleared by flush.
- cnt per channel: +1 on write only, −1 on read only, unchanged on both or neither.
- Next-state flags are computed from next pointers:
  - full = wrap bits differ & low bits equal.
  - empty = pointers equal.
  - afull = (2^CH_DEPTH_LG2 − cnt_n) ≤ AFULL_MARGIN.
- A simultaneous write and read to the same channel are both legal when the channel is neither full nor empty. Writes and reads to different channels are always independent.
- rdata_o holds the last returned value while rvalid_o = 0. rdata_o is unspecified before the first read.
- No state machine beyond per-channel pointers. There is no bypass path: a channel's empty flag never depends on the same-cycle write.

## Timing
- Reset (rst_n = 0, sampled at posedge):
  - Pointers and cnt = 0.
  - full_o = all 1s and afull_o = all 1s, so wready_o = 0 while in reset.
  - empty_o = all 1s, rvalid_o = 0, rch_o = 0, undrflown = 0.
- First cycle after reset release: full_o = 0, afull_o = 0.
- Reset mid-operation discards all contents. Any read returned in that cycle is suppressed (rvalid_o = 0).
- Write at cycle N to an empty channel: empty_o clears at N+1; earliest read request at N+1; data at N+2. Write-to-read latency is 2.
- Read accepted at N: rvalid_o, rch_o and rdata_o are valid at N+1. A read may be accepted every cycle.
- Write that fills the last entry at N: full_o and ~wready_o for that channel at N+1. A read at N frees an entry visible at N+1.
- Flags and cnt_o are registered; wready_o is combinational only through the wch_i mux.

## Test plan
- Reset defaults, NUM_CH=4, CH_DEPTH_LG2=4: hold rst_n = 0 for 3 cycles → wready_o = 0, full_o = 4'hF, empty_o = 4'hF. After release → full_o = 0, cnt_o = 0, debug_o = 32'h0.
- Fill ch2 with 16 writes of data 0..15 → full_o[2] = 1 from cycle 17; afull_o[2] = 1 once cnt ≥ 14. A 17th write is not accepted. Popping 16 times returns 0..15 in order with rch_o = 2.
- Isolation: fill ch0, then write ch1 → ch1 writes accepted. Interleaved reads ch0/ch1 return per-channel FIFO order.
- Simultaneous push and pop on ch3 with cnt = 5 for 100 cycles → cnt stays 5; data order is preserved across pointer wrap-around (more than 32 pushes).
- Read ch1 while empty → rvalid_o = 0, debug_o[1] = 1 and stays set after subsequent traffic and flush. The assertion fires.
- Flush ch0 at cnt = 7 with concurrent write and read to ch0 → both dropped. Next cycle: cnt = 0, empty_o[0] = 1, and other channels are unchanged.
